// File: rtl/vga_timing_gen_if.sv
// Pixel request bus between the VGA timing engine (master) and a picture source (slave).
interface vga_timing_gen_if #(
  parameter int CNT_W   = 12,
  parameter int COLOR_W = 16
);
  logic               data_req;
  logic [CNT_W-1:0]   pix_x;
  logic [CNT_W-1:0]   pix_y;
  logic [COLOR_W-1:0] pix_data;

  modport master (
    output data_req, pix_x, pix_y,
    input  pix_data
  );

  modport slave (
    input  data_req, pix_x, pix_y,
    output pix_data
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing engine with lead-compensated pixel requests.
// Optional colour-bar generator is built when VGA_TEST_PATTERN_EN is defined.
module vga_timing_gen #(
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int H_POL    = 0,
  parameter int V_POL    = 0,
  parameter int PIX_LEAD = 1,
  parameter int CNT_W    = 12,
  parameter int COLOR_W  = 16
) (
  input  logic                vga_clk,
  input  logic                sys_rst,
  vga_timing_gen_if.master    pix,
  input  logic                test_en,
  output logic                hsync,
  output logic                vsync,
  output logic                de,
  output logic [COLOR_W-1:0]  rgb,
  output logic                frame_start,
  output logic [15:0]         frame_cnt
);

  localparam int   H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int   V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int   HA0     = H_SYNC + H_BP;
  localparam int   VA0     = V_SYNC + V_BP;
  localparam logic HS_ON   = (H_POL != 0);
  localparam logic VS_ON   = (V_POL != 0);

  logic [CNT_W-1:0]   h_cnt;
  logic [CNT_W-1:0]   v_cnt;
  logic               h_wrap;
  logic               v_wrap;
  logic               h_act;
  logic               v_act;
  logic               req_int;
  logic [CNT_W:0]     h_lead;
  logic [COLOR_W-1:0] color_in;

  assign h_wrap = (h_cnt == CNT_W'(H_TOTAL - 1));
  assign v_wrap = (v_cnt == CNT_W'(V_TOTAL - 1));

  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      h_cnt     <= '0;
      v_cnt     <= '0;
      frame_cnt <= '0;
    end else begin
      h_cnt <= h_wrap ? '0 : h_cnt + CNT_W'(1);
      if (h_wrap) begin
        v_cnt <= v_wrap ? '0 : v_cnt + CNT_W'(1);
        if (v_wrap)
          frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

  assign h_act = (h_cnt >= CNT_W'(HA0)) && (h_cnt < CNT_W'(HA0 + H_ACTIVE));
  assign v_act = (v_cnt >= CNT_W'(VA0)) && (v_cnt < CNT_W'(VA0 + V_ACTIVE));

  // One extra bit so the look-ahead position cannot alias near the end of a line.
  assign h_lead  = {1'b0, h_cnt} + (CNT_W+1)'(PIX_LEAD);
  assign req_int = v_act && (h_lead >= (CNT_W+1)'(HA0))
                         && (h_lead <  (CNT_W+1)'(HA0 + H_ACTIVE));

  assign pix.data_req = req_int;
  assign pix.pix_x    = req_int ? CNT_W'(h_lead - (CNT_W+1)'(HA0)) : '1;
  assign pix.pix_y    = req_int ? v_cnt - CNT_W'(VA0) : '1;

`ifdef VGA_TEST_PATTERN_EN
  logic               test_sel;
  logic [2:0]         bar_idx;
  logic [COLOR_W-1:0] bar_col;
  logic [COLOR_W-1:0] bar_dly;

  assign bar_idx = 3'({pix.pix_x, 3'b000} / (CNT_W+3)'(H_ACTIVE));

  always_comb begin
    bar_col = '0;
    case (bar_idx)
      3'd0: bar_col = COLOR_W'(16'hFFFF);
      3'd1: bar_col = COLOR_W'(16'hFFE0);
      3'd2: bar_col = COLOR_W'(16'h07FF);
      3'd3: bar_col = COLOR_W'(16'h07E0);
      3'd4: bar_col = COLOR_W'(16'hF81F);
      3'd5: bar_col = COLOR_W'(16'hF800);
      3'd6: bar_col = COLOR_W'(16'h001F);
      3'd7: bar_col = COLOR_W'(16'h0000);
      default: bar_col = '0;
    endcase
  end

  // Bars travel through the same latency an external source would add.
  if (PIX_LEAD == 0) begin : g_bar_nodly
    assign bar_dly = bar_col;
  end else begin : g_bar_dly
    logic [COLOR_W-1:0] pipe [PIX_LEAD];
    always_ff @(posedge vga_clk) begin
      pipe[0] <= bar_col;
      for (int i = 1; i < PIX_LEAD; i++)
        pipe[i] <= pipe[i-1];
    end
    assign bar_dly = pipe[PIX_LEAD-1];
  end

  // Only latched on the frame's first cycle so a frame is never half bars.
  always_ff @(posedge vga_clk) begin
    if (sys_rst)
      test_sel <= 1'b0;
    else if (h_cnt == '0 && v_cnt == '0)
      test_sel <= test_en;
  end

  assign color_in = test_sel ? bar_dly : pix.pix_data;
`else
  logic test_en_unused;
  assign test_en_unused = test_en;
  assign color_in       = pix.pix_data;
`endif

  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      hsync       <= ~HS_ON;
      vsync       <= ~VS_ON;
      de          <= 1'b0;
      rgb         <= '0;
      frame_start <= 1'b0;
    end else begin
      hsync       <= (h_cnt < CNT_W'(H_SYNC)) ? HS_ON : ~HS_ON;
      vsync       <= (v_cnt < CNT_W'(V_SYNC)) ? VS_ON : ~VS_ON;
      de          <= h_act && v_act;
      rgb         <= (h_act && v_act) ? color_in : '0;
      frame_start <= (h_cnt == '0) && (v_cnt == '0);
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (lead 0, 1, 3; the last with H_POL=1)
// on a reduced raster, checked every cycle against a position-based model.
module tb_vga_timing_gen;

  localparam int HS  = 4, HBP = 3, HA = 16, HFP = 2;
  localparam int VS  = 2, VBP = 2, VA = 6,  VFP = 1;
  localparam int HT  = HS + HBP + HA + HFP;
  localparam int VT  = VS + VBP + VA + VFP;
  localparam int FR  = HT * VT;
  localparam int HA0 = HS + HBP;
  localparam int VA0 = VS + VBP;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic sys_rst;
  logic test_en;

  logic        req_a   [3];
  logic [11:0] px_a    [3];
  logic [11:0] py_a    [3];
  logic        hsync_a [3];
  logic        vsync_a [3];
  logic        de_a    [3];
  logic        fs_a    [3];
  logic [15:0] rgb_a   [3];
  logic [15:0] fc_a    [3];

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LEAD = (g == 0) ? 0 : (g == 1) ? 1 : 3;
    localparam int HPOL = (g == 2) ? 1 : 0;

    vga_timing_gen_if #(.CNT_W(12), .COLOR_W(16)) bus ();

    vga_timing_gen #(
      .H_SYNC(HS), .H_BP(HBP), .H_ACTIVE(HA), .H_FP(HFP),
      .V_SYNC(VS), .V_BP(VBP), .V_ACTIVE(VA), .V_FP(VFP),
      .H_POL(HPOL), .V_POL(0), .PIX_LEAD(LEAD), .CNT_W(12), .COLOR_W(16)
    ) u_dut (
      .vga_clk     (clk),
      .sys_rst     (sys_rst),
      .pix         (bus),
      .test_en     (test_en),
      .hsync       (hsync_a[g]),
      .vsync       (vsync_a[g]),
      .de          (de_a[g]),
      .rgb         (rgb_a[g]),
      .frame_start (fs_a[g]),
      .frame_cnt   (fc_a[g])
    );

    // Picture source: returns {y,x} of the requested pixel LEAD cycles later.
    if (LEAD == 0) begin : g_src0
      assign bus.pix_data = {bus.pix_y[7:0], bus.pix_x[7:0]};
    end else begin : g_srcn
      logic [15:0] sr [LEAD];
      always @(posedge clk) begin
        sr[0] <= {bus.pix_y[7:0], bus.pix_x[7:0]};
        for (int j = 1; j < LEAD; j++)
          sr[j] <= sr[j-1];
      end
      assign bus.pix_data = sr[LEAD-1];
    end

    assign req_a[g] = bus.data_req;
    assign px_a[g]  = bus.pix_x;
    assign py_a[g]  = bus.pix_y;
  end

  // Model: raster position since the last reset edge, and the position one cycle earlier.
  int pos      = 0;
  int prev_pos = 0;
  bit prev_valid = 1'b0;
  bit model_on   = 1'b0;
  bit tsel       = 1'b0;
  bit prev_tsel  = 1'b0;

  always @(posedge clk) begin
    if (sys_rst) begin
      pos        <= 0;
      prev_valid <= 1'b0;
      model_on   <= 1'b1;
      tsel       <= 1'b0;
      prev_tsel  <= 1'b0;
    end else if (model_on) begin
      prev_pos   <= pos;
      pos        <= pos + 1;
      prev_valid <= 1'b1;
      prev_tsel  <= tsel;
      if (pos % FR == 0)
        tsel <= test_en;
    end
  end

  function automatic logic [15:0] barOf(input int idx);
    case (idx)
      0: return 16'hFFFF;
      1: return 16'hFFE0;
      2: return 16'h07FF;
      3: return 16'h07E0;
      4: return 16'hF81F;
      5: return 16'hF800;
      6: return 16'h001F;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic checkOutput(input string name, input int inst,
                             input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s inst%0d pos=%0d got=%0h exp=%0h", name, inst, pos, got, exp);
    end
  endtask

  task automatic applyStimulus(input bit rst, input bit ten, input int n);
    sys_rst = rst;
    test_en = ten;
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin : cmp
    int h, v, ph, pv, hx, lead;
    bit req, act, hpol;
    logic [15:0] rgb_exp;
    if (model_on) begin
      h   = pos % HT;
      v   = (pos / HT) % VT;
      ph  = prev_pos % HT;
      pv  = (prev_pos / HT) % VT;
      act = prev_valid && ph >= HA0 && ph < HA0 + HA && pv >= VA0 && pv < VA0 + VA;
      rgb_exp = act ? {8'(pv - VA0), 8'(ph - HA0)} : 16'h0000;
`ifdef VGA_TEST_PATTERN_EN
      if (act && prev_tsel)
        rgb_exp = barOf((ph - HA0) * 8 / HA);
`endif
      for (int i = 0; i < 3; i++) begin
        lead = (i == 0) ? 0 : (i == 1) ? 1 : 3;
        hpol = (i == 2);
        hx   = h + lead;
        req  = v >= VA0 && v < VA0 + VA && hx >= HA0 && hx < HA0 + HA;
        checkOutput("data_req", i, 32'(req_a[i]), 32'(req));
        checkOutput("pix_x", i, 32'(px_a[i]), req ? 32'(hx - HA0) : 32'hFFF);
        checkOutput("pix_y", i, 32'(py_a[i]), req ? 32'(v - VA0) : 32'hFFF);
        checkOutput("hsync", i, 32'(hsync_a[i]),
                    prev_valid ? 32'((ph < HS) == hpol) : 32'(!hpol));
        checkOutput("vsync", i, 32'(vsync_a[i]), prev_valid ? 32'(!(pv < VS)) : 32'd1);
        checkOutput("de", i, 32'(de_a[i]), 32'(act));
        checkOutput("rgb", i, 32'(rgb_a[i]), 32'(rgb_exp));
        checkOutput("frame_start", i, 32'(fs_a[i]),
                    32'(prev_valid && (prev_pos % FR == 0)));
        checkOutput("frame_cnt", i, 32'(fc_a[i]), 32'((pos / FR) % 65536));
      end
    end
  end

  initial begin
    int hlow, hhigh2, vlow, vlow2, de_cnt, fs_cnt, last_fs;
    logic [15:0] exp_p0, exp_p2, exp_p15;
    hlow = 0; hhigh2 = 0; vlow = 0; vlow2 = 0; de_cnt = 0; fs_cnt = 0; last_fs = -1;

    applyStimulus(1'b1, 1'b0, 10);
    checkOutput("rst_hsync", 1, 32'(hsync_a[1]), 32'd1);
    checkOutput("rst_hsync_pol1", 2, 32'(hsync_a[2]), 32'd0);
    checkOutput("rst_vsync", 1, 32'(vsync_a[1]), 32'd1);
    checkOutput("rst_de", 1, 32'(de_a[1]), 32'd0);
    checkOutput("rst_rgb", 1, 32'(rgb_a[1]), 32'd0);
    checkOutput("rst_frame_start", 1, 32'(fs_a[1]), 32'd0);
    checkOutput("rst_frame_cnt", 1, 32'(fc_a[1]), 32'd0);
    checkOutput("rst_pix_x", 1, 32'(px_a[1]), 32'hFFF);

    // Three frames from release; after the k-th falling edge the raster position is k.
    sys_rst = 1'b0;
    for (int k = 1; k <= 3 * FR; k++) begin
      @(negedge clk);
      if (k <= HT && !hsync_a[1]) hlow++;
      if (k <= HT && hsync_a[2])  hhigh2++;
      if (k <= FR && !vsync_a[1]) vlow++;
      if (k <= FR && !vsync_a[2]) vlow2++;
      if (k <= FR && de_a[1])     de_cnt++;
      if (fs_a[1]) begin
        if (last_fs >= 0)
          checkOutput("fs_period", 1, 32'(k - last_fs), 32'd275);
        last_fs = k;
        fs_cnt++;
      end
      if (k == 105) begin
        checkOutput("req_before_first", 1, 32'(req_a[1]), 32'd0);
        checkOutput("pix_x_before_first", 1, 32'(px_a[1]), 32'hFFF);
      end
      if (k == 106) begin
        checkOutput("req_first", 1, 32'(req_a[1]), 32'd1);
        checkOutput("pix_x_first", 1, 32'(px_a[1]), 32'd0);
        checkOutput("pix_y_first", 1, 32'(py_a[1]), 32'd0);
      end
      if (k == 246) begin
        checkOutput("pix_x_last", 1, 32'(px_a[1]), 32'd15);
        checkOutput("pix_y_last", 1, 32'(py_a[1]), 32'd5);
      end
      if (k == 247)
        checkOutput("pix_y_after_last", 1, 32'(py_a[1]), 32'hFFF);
      if (k == 161)
        for (int i = 0; i < 3; i++)
          checkOutput("rgb_x3_y2", i, 32'(rgb_a[i]), 32'h0203);
      if (k == 274) checkOutput("frame_cnt_274", 1, 32'(fc_a[1]), 32'd0);
      if (k == 275) checkOutput("frame_cnt_275", 1, 32'(fc_a[1]), 32'd1);
    end
    checkOutput("hsync_low_per_line", 1, 32'(hlow), 32'd4);
    checkOutput("hsync_high_per_line_pol1", 2, 32'(hhigh2), 32'd4);
    checkOutput("vsync_low_per_frame", 1, 32'(vlow), 32'd50);
    checkOutput("vsync_low_per_frame_pol1", 2, 32'(vlow2), 32'd50);
    checkOutput("de_per_frame", 1, 32'(de_cnt), 32'd96);
    checkOutput("frame_start_count", 1, 32'(fs_cnt), 32'd3);
    checkOutput("frame_cnt_3", 1, 32'(fc_a[1]), 32'd3);

    // Into line 8 (an active line), mid-line, then reset for one edge.
    applyStimulus(1'b0, 1'b0, 210);
    applyStimulus(1'b1, 1'b0, 1);
    checkOutput("midrst_de", 1, 32'(de_a[1]), 32'd0);
    checkOutput("midrst_rgb", 1, 32'(rgb_a[1]), 32'd0);
    checkOutput("midrst_hsync", 1, 32'(hsync_a[1]), 32'd1);
    checkOutput("midrst_frame_cnt", 1, 32'(fc_a[1]), 32'd0);
    checkOutput("midrst_frame_start", 1, 32'(fs_a[1]), 32'd0);
    checkOutput("midrst_req", 1, 32'(req_a[1]), 32'd0);
    applyStimulus(1'b0, 1'b0, 1);
    checkOutput("release_frame_start", 1, 32'(fs_a[1]), 32'd1);

    // test_en raised mid-frame 0; any bars must wait for frame 1.
`ifdef VGA_TEST_PATTERN_EN
    exp_p0 = 16'hFFFF; exp_p2 = 16'hFFE0; exp_p15 = 16'h0000;
`else
    exp_p0 = 16'h0000; exp_p2 = 16'h0002; exp_p15 = 16'h000F;
`endif
    test_en = 1'b1;
    for (int k = 2; k <= 2 * FR + 10; k++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (k == 161) checkOutput("tp_frame0_x3_y2", i, 32'(rgb_a[i]), 32'h0203);
        if (k == 383) checkOutput("tp_frame1_x0", i, 32'(rgb_a[i]), 32'(exp_p0));
        if (k == 385) checkOutput("tp_frame1_x2", i, 32'(rgb_a[i]), 32'(exp_p2));
        if (k == 398) checkOutput("tp_frame1_x15", i, 32'(rgb_a[i]), 32'(exp_p15));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA timing engine; successor to the fixed 640x480 controller.
- Generates hsync/vsync, data enable, and pixel-request coordinates with a configurable lead, so picture sources with PIX_LEAD-cycle pipeline latency line up exactly with the active window.
- Sits between the PLL-derived pixel clock and the picture generator (char/pic/ROM sources); drives the RGB565 (or wider) DAC pins.

Parameters:
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch
- H_ACTIVE, 640, horizontal active pixels
- H_FP, 16, horizontal front porch
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch
- V_ACTIVE, 480, vertical active lines
- V_FP, 10, vertical front porch
- H_POL, 0, hsync active level (0 = active-low)
- V_POL, 0, vsync active level
- PIX_LEAD, 1, cycles pix_data lags data_req; legal range 0..H_BP
- CNT_W, 12, width of internal counters and pix_x/pix_y
- COLOR_W, 16, width of pix_data/rgb

Ports:
- vga_clk  in  1  pixel clock; all logic on its rising edge
- sys_rst  in  1  reset; synchronous, active-high
- pix_data  in  COLOR_W  pixel colour; returned PIX_LEAD cycles after its data_req
- test_en  in  1  selects internal colour bars (only with VGA_TEST_PATTERN_EN)
- data_req  out  1  pixel request, PIX_LEAD cycles ahead of active display
- pix_x  out  CNT_W  x of requested pixel; all-ones when data_req=0
- pix_y  out  CNT_W  y of requested pixel; all-ones when data_req=0
- hsync  out  1  line sync
- vsync  out  1  field sync
- de  out  1  display enable (active region)
- rgb  out  COLOR_W  colour output
- frame_start  out  1  one-cycle pulse at first cycle of each frame (h=0,v=0)
- frame_cnt  out  16  frames completed since reset, wraps

Behaviour:
- H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP. V_TOTAL is defined likewise.
- h_cnt counts 0..H_TOTAL-1 and wraps to 0.
- v_cnt increments when h_cnt wraps; v_cnt wraps at V_TOTAL-1 to 0.
- Segment order, both axes: sync, back porch, active, front porch.
- HA0 = H_SYNC+H_BP; VA0 = V_SYNC+V_BP.
- Internal active flags:
  - h_act = HA0 <= h_cnt < HA0+H_ACTIVE
  - v_act = VA0 <= v_cnt < VA0+V_ACTIVE
- Request window: req_int = v_act && HA0 <= h_cnt+PIX_LEAD < HA0+H_ACTIVE. Since PIX_LEAD <= H_BP, the window never crosses a line.
- data_req, pix_x, pix_y are combinational from the counters:
  - pix_x = h_cnt+PIX_LEAD-HA0 while req_int; else all-ones
  - pix_y = v_cnt-VA0 while req_int; else all-ones
- hsync, vsync, de, rgb, frame_start are registered, one cycle after the counter state they decode:
  - hsync = H_POL when h_cnt < H_SYNC, else ~H_POL
  - vsync = V_POL when v_cnt < V_SYNC, else ~V_POL
  - de = h_act && v_act
  - rgb = pix_data (sampled while h_act && v_act), else 0
- Net alignment: pixel requested in cycle t appears on rgb in cycle t+PIX_LEAD+1.
- With PIX_LEAD=0, data_req equals the internal active flag and pix_data is expected combinationally.
- frame_start registers (h_cnt==0 && v_cnt==0).
- frame_cnt increments on the cycle h_cnt and v_cnt both wrap to 0.
- Reset state (sys_rst high at a clock edge):
  - h_cnt=v_cnt=0, frame_cnt=0
  - hsync=~H_POL, vsync=~V_POL
  - de=0, rgb=0, frame_start=0
- Reset mid-frame: counters return to 0 on the next edge. The first cycle after release is h=0,v=0, so frame_start pulses one cycle after release.
- No handshake back-pressure: the source must always deliver pix_data on time.

Optional Feature:
- Macro: VGA_TEST_PATTERN_EN.
- Defined:
  - Internal 8-bar generator; bar index = pix_x[CNT_W-1:0]*8/H_ACTIVE.
  - RGB565 bars, in order: white FFFF, yellow FFE0, cyan 07FF, green 07E0, magenta F81F, red F800, blue 001F, black 0000.
  - Bars are delayed PIX_LEAD cycles to match the external path.
  - When test_en=1, bar colour replaces pix_data. test_en is sampled at frame_start only, so no mid-frame tearing.
- Undefined: test_en is ignored and generator logic is absent.

Test Plan:
- Defaults; reset 10 cycles then release -> hsync low exactly 96 cycles per 800-cycle line; vsync low exactly 2 lines (1600 cycles) per 420000-cycle frame.
- Defaults, PIX_LEAD=1 -> first data_req of frame at h_cnt=143, v_cnt=35 with pix_x=0, pix_y=0; last at pix_x=639, pix_y=479; pix_x=pix_y=12'hFFF elsewhere.
- Source returning pix_data={pix_y[7:0],pix_x[7:0]} after PIX_LEAD (try 0, 1, 3) -> rgb matches per pixel under de; rgb=0 when de=0; de high 640 cycles per line on 480 lines.
- Assert sys_rst mid-line at v=200 -> next edge h=v=0; outputs at reset values; frame_start pulses one cycle after release; frame_cnt=0.
- Run 3 frames -> frame_start pulses exactly every 420000 cycles; frame_cnt=3; H_POL=1 variant inverts hsync only.
- VGA_TEST_PATTERN_EN defined, test_en=1 set mid-frame -> bars appear from next frame: pixel 0 = FFFF, pixel 80 = FFE0, pixel 639 = 0000.
